// File: rtl/fnd_scan_controller.sv
// ---------------------------------------------------------------------------
// fnd_scan_controller
//   Time-multiplexes the stopwatch counts onto a 4-digit common-anode
//   7-segment display. One digit is lit per scan slot of SCAN_DIV clocks.
//   The time is snapshotted once per frame (on the slot that lights digit 0)
//   so a frame never mixes old and new values. mode selects sec.msec or
//   hour.min. The decimal point on digit 2 blinks at 1 Hz (lit while the
//   frame's msec < 50).
//
// Ports
//   clk       in   1  system clock
//   rst       in   1  synchronous reset, active-high
//   mode      in   1  0: sec.msec view, 1: hour.min view
//   msec      in   7  centiseconds, 0..99
//   sec       in   6  seconds, 0..59
//   min       in   6  minutes, 0..59
//   hour      in   5  hours, 0..23
//   fnd_com   out  4  digit enables, active-low, bit0 = rightmost digit
//   fnd_data  out  8  segments, active-low, [7]=dp, [6:0]=gfedcba
// ---------------------------------------------------------------------------
module fnd_scan_controller #(
   parameter int SCAN_DIV = 100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic [6:0] msec,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hour,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);

   localparam int              CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] scan_cnt_r;
   logic [1:0]    ptr_r;
   logic          sh_mode_r;
   logic [6:0]    sh_msec_r;
   logic [5:0]    sh_sec_r;
   logic [5:0]    sh_min_r;
   logic [4:0]    sh_hour_r;
   logic [3:0]    fnd_com_r;
   logic [7:0]    fnd_data_r;

   logic          tick_s;
   logic [1:0]    ptr_nxt_s;
   logic          wrap_s;
   logic          src_mode_s;
   logic [6:0]    src_msec_s;
   logic [5:0]    src_sec_s;
   logic [5:0]    src_min_s;
   logic [4:0]    src_hour_s;
   logic [6:0]    hi_s;
   logic [6:0]    lo_s;
   logic [6:0]    digit_s;
   logic [3:0]    com_s;
   logic [7:0]    seg_s;
   logic [7:0]    data_s;

   // Active-low segment code for one decimal digit; anything above 9 is blank.
   function automatic logic [7:0] seg_code(input logic [6:0] v);
      logic [7:0] code;
      case (v)
         7'd0:    code = 8'hC0;
         7'd1:    code = 8'hF9;
         7'd2:    code = 8'hA4;
         7'd3:    code = 8'hB0;
         7'd4:    code = 8'h99;
         7'd5:    code = 8'h92;
         7'd6:    code = 8'h82;
         7'd7:    code = 8'hF8;
         7'd8:    code = 8'h80;
         7'd9:    code = 8'h90;
         default: code = 8'hFF;
      endcase
      return code;
   endfunction

   // Pattern for the digit about to be lit; digit 0 takes the live inputs
   // because the shadow is only being loaded on that same edge.
   always_comb begin
      tick_s     = (scan_cnt_r == CNT_LAST);
      ptr_nxt_s  = ptr_r + 2'd1;
      wrap_s     = (ptr_nxt_s == 2'd0);
      src_mode_s = wrap_s ? mode : sh_mode_r;
      src_msec_s = wrap_s ? msec : sh_msec_r;
      src_sec_s  = wrap_s ? sec  : sh_sec_r;
      src_min_s  = wrap_s ? min  : sh_min_r;
      src_hour_s = wrap_s ? hour : sh_hour_r;
      hi_s       = src_mode_s ? {2'b00, src_hour_s} : {1'b0, src_sec_s};
      lo_s       = src_mode_s ? {1'b0, src_min_s}   : src_msec_s;
      case (ptr_nxt_s)
         2'd0: begin digit_s = lo_s % 7'd10; com_s = 4'b1110; end
         2'd1: begin digit_s = lo_s / 7'd10; com_s = 4'b1101; end
         2'd2: begin digit_s = hi_s % 7'd10; com_s = 4'b1011; end
         2'd3: begin digit_s = hi_s / 7'd10; com_s = 4'b0111; end
         default: begin digit_s = 7'd127; com_s = 4'b1111; end
      endcase
      seg_s = seg_code(digit_s);
      // Blinking dp on digit 2 follows the frame's msec, never on a blank digit.
      if ((ptr_nxt_s == 2'd2) && (seg_s != 8'hFF) && (sh_msec_r < 7'd50)) begin
         data_s = {1'b0, seg_s[6:0]};
      end else begin
         data_s = seg_s;
      end
   end

   // Slot counter and digit pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_r <= '0;
         ptr_r      <= 2'd3;
      end else if (tick_s) begin
         scan_cnt_r <= '0;
         ptr_r      <= ptr_nxt_s;
      end else begin
         scan_cnt_r <= scan_cnt_r + CW'(1);
      end
   end

   // Frame snapshot, loaded when the pointer wraps to digit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_mode_r <= 1'b0;
         sh_msec_r <= 7'd0;
         sh_sec_r  <= 6'd0;
         sh_min_r  <= 6'd0;
         sh_hour_r <= 5'd0;
      end else if (tick_s && wrap_s) begin
         sh_mode_r <= mode;
         sh_msec_r <= msec;
         sh_sec_r  <= sec;
         sh_min_r  <= min;
         sh_hour_r <= hour;
      end
   end

   // Registered display outputs, updated only on slot ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         fnd_com_r  <= 4'b1111;
         fnd_data_r <= 8'hFF;
      end else if (tick_s) begin
         fnd_com_r  <= com_s;
         fnd_data_r <= data_s;
      end
   end

   assign fnd_com  = fnd_com_r;
   assign fnd_data = fnd_data_r;

endmodule
